// File: rtl/csr_trap_seq.sv
// rtl/csr_trap_seq.sv - CSR port initiator: pipeline passthrough plus trap-entry / MRET sequencer
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pipe_csr_*          pipeline CSR op (addr/wdata/we in, rdata/stall out)
//   trap_req/pc/cause/tval, mret_req   sequence requests (one-cycle pulses)
//   busy                sequencer owns the CSR port
//   redirect_valid/pc   one-cycle fetch redirect at end of a sequence
//   csr_addr/wdata/we   drive to CSR file; csr_rdata is combinational on csr_addr
module csr_trap_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     pipe_csr_addr,
    input  logic [XLEN-1:0] pipe_csr_wdata,
    input  logic [1:0]      pipe_csr_we,
    output logic [XLEN-1:0] pipe_csr_rdata,
    output logic            pipe_csr_stall,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [1:0]      csr_we,
    input  logic [XLEN-1:0] csr_rdata
);

    localparam logic [1:0]  WE_NONE = 2'b00;
    localparam logic [1:0]  WE_CSRW = 2'b01;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T_EPC,
        S_T_CAUSE,
        S_T_TVAL,
        S_T_STAT,
        S_T_VEC,
        S_R_STAT,
        S_R_SYNC,
        S_R_EPC
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] redir_q, redir_d;

    logic [XLEN-1:0] aligned_rdata;
    logic [XLEN-1:0] vec_target;
    logic [XLEN-1:0] stat_trap;
    logic [XLEN-1:0] stat_mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        aligned_rdata = {csr_rdata[XLEN-1:2], 2'b00};
        // Vectored mode only applies to interrupts; mode 1x falls back to direct.
        if (csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1]) begin
            vec_target = aligned_rdata + {cause_q[XLEN-3:0], 2'b00};
        end else begin
            vec_target = aligned_rdata;
        end
        // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
        stat_trap        = csr_rdata;
        stat_trap[7]     = csr_rdata[3];
        stat_trap[3]     = 1'b0;
        stat_trap[12:11] = 2'b11;
        // MRET: MIE <- MPIE, MPIE <- 1, MPP stays M (only mode implemented).
        stat_mret        = csr_rdata;
        stat_mret[3]     = csr_rdata[7];
        stat_mret[7]     = 1'b1;
        stat_mret[12:11] = 2'b11;
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        tval_d         = tval_q;
        redir_d        = redir_q;
        csr_addr       = '0;
        csr_wdata      = '0;
        csr_we         = WE_NONE;
        pipe_csr_rdata = csr_rdata;
        pipe_csr_stall = 1'b1;
        busy           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = redir_q;

        case (state_q)
            S_IDLE: begin
                busy           = 1'b0;
                csr_addr       = pipe_csr_addr;
                csr_wdata      = pipe_csr_wdata;
                csr_we         = pipe_csr_we;
                pipe_csr_stall = trap_req | mret_req;
                if (trap_req) begin
                    csr_we  = WE_NONE;
                    pc_d    = trap_pc & ~XLEN'(3);
                    cause_d = trap_cause;
                    tval_d  = trap_tval;
                    state_d = S_T_EPC;
                end else if (mret_req) begin
                    csr_we  = WE_NONE;
                    state_d = S_R_STAT;
                end
            end
            S_T_EPC: begin
                csr_addr  = A_MEPC;
                csr_we    = WE_CSRW;
                csr_wdata = pc_q;
                state_d   = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_addr  = A_MCAUSE;
                csr_we    = WE_CSRW;
                csr_wdata = cause_q;
                state_d   = S_T_TVAL;
            end
            S_T_TVAL: begin
                csr_addr  = A_MTVAL;
                csr_we    = WE_CSRW;
                csr_wdata = tval_q;
                state_d   = S_T_STAT;
            end
            S_T_STAT: begin
                csr_addr  = A_MSTATUS;
                csr_we    = WE_CSRW;
                csr_wdata = stat_trap;
                state_d   = S_T_VEC;
            end
            S_T_VEC: begin
                csr_addr       = A_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = vec_target;
                redir_d        = vec_target;
                state_d        = S_IDLE;
            end
            S_R_STAT: begin
                csr_addr  = A_MSTATUS;
                csr_we    = WE_CSRW;
                csr_wdata = stat_mret;
                state_d   = S_R_SYNC;
            end
            S_R_SYNC: begin
                // Port held quiet for one cycle so the MRET redirect lands at
                // acceptance+3 and the MSTATUS write has committed before MEPC is read.
                state_d = S_R_EPC;
            end
            S_R_EPC: begin
                csr_addr       = A_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = aligned_rdata;
                redir_d        = aligned_rdata;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset cycle must not commit a CSR write or fire a redirect.
        if (rst) begin
            csr_addr       = '0;
            csr_wdata      = '0;
            csr_we         = WE_NONE;
            redirect_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
// tb/tb_csr_trap_seq.sv - directed self-checking bench for csr_trap_seq
module tb_csr_trap_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pipe_csr_addr = '0;
    logic [31:0] pipe_csr_wdata = '0;
    logic [1:0]  pipe_csr_we = '0;
    logic [31:0] pipe_csr_rdata;
    logic        pipe_csr_stall;
    logic        trap_req = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_tval = '0;
    logic        mret_req = 1'b0;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_we;
    logic [31:0] csr_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csr_trap_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
        .pipe_csr_we(pipe_csr_we), .pipe_csr_rdata(pipe_csr_rdata),
        .pipe_csr_stall(pipe_csr_stall),
        .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_req(mret_req),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we),
        .csr_rdata(csr_rdata)
    );

    // Small CSR file: combinational read, write commits at the clock edge.
    logic [31:0] mstatus = '0, mtvec = '0, mepc = '0, mcause = '0, mtval = '0;
    logic [31:0] mscratch = 32'h0000_000F;

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = mstatus;
            12'h305: csr_rdata = mtvec;
            12'h340: csr_rdata = mscratch;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'h343: csr_rdata = mtval;
            default: csr_rdata = '0;
        endcase
    end

    function automatic logic [31:0] wval(input logic [1:0] we, input logic [31:0] rd, input logic [31:0] wd);
        case (we)
            2'b01:   return wd;
            2'b10:   return rd | wd;
            default: return rd & ~wd;
        endcase
    endfunction

    always @(posedge clk) begin
        if (csr_we != 2'b00) begin
            case (csr_addr)
                12'h300: mstatus  <= wval(csr_we, csr_rdata, csr_wdata);
                12'h305: mtvec    <= wval(csr_we, csr_rdata, csr_wdata);
                12'h340: mscratch <= wval(csr_we, csr_rdata, csr_wdata);
                12'h341: mepc     <= wval(csr_we, csr_rdata, csr_wdata);
                12'h342: mcause   <= wval(csr_we, csr_rdata, csr_wdata);
                12'h343: mtval    <= wval(csr_we, csr_rdata, csr_wdata);
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pipe_csr_addr  = a;
        pipe_csr_wdata = d;
        pipe_csr_we    = 2'b01;
        @(negedge clk);
        pipe_csr_we    = 2'b00;
        pipe_csr_addr  = '0;
        pipe_csr_wdata = '0;
    endtask

    task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval,
                            input logic mret_too, input logic [31:0] exp_epc,
                            input logic [31:0] exp_stat, input logic [31:0] exp_red);
        logic [11:0] ea [1:5];
        logic [1:0]  ew [1:5];
        logic [31:0] ed [1:5];
        ea[1] = 12'h341; ew[1] = 2'b01; ed[1] = exp_epc;
        ea[2] = 12'h342; ew[2] = 2'b01; ed[2] = cause;
        ea[3] = 12'h343; ew[3] = 2'b01; ed[3] = tval;
        ea[4] = 12'h300; ew[4] = 2'b01; ed[4] = exp_stat;
        ea[5] = 12'h305; ew[5] = 2'b00; ed[5] = 32'h0;
        @(negedge clk);
        trap_req = 1'b1; mret_req = mret_too;
        trap_pc = pc; trap_cause = cause; trap_tval = tval;
        pipe_csr_addr = 12'h340; pipe_csr_wdata = 32'h55; pipe_csr_we = 2'b01;
        #1;
        check("acc_stall", {31'b0, pipe_csr_stall}, 32'd1);
        check("acc_we", {30'b0, csr_we}, 32'd0);
        check("acc_busy", {31'b0, busy}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                trap_req = 1'b0; mret_req = 1'b0; pipe_csr_we = 2'b00;
                trap_pc = 32'hFFFF_FFFF; trap_cause = 32'h1234_5678; trap_tval = 32'h0;
            end
            mret_req = (c == 2) && mret_too;
            #1;
            check($sformatf("c%0d_addr", c), {20'b0, csr_addr}, {20'b0, ea[c]});
            check($sformatf("c%0d_we", c), {30'b0, csr_we}, {30'b0, ew[c]});
            check($sformatf("c%0d_wdata", c), csr_wdata, ed[c]);
            check($sformatf("c%0d_busy", c), {31'b0, busy & pipe_csr_stall}, 32'd1);
            check($sformatf("c%0d_rv", c), {31'b0, redirect_valid}, {31'b0, c == 5});
        end
        check("red_pc", redirect_pc, exp_red);
        mret_req = 1'b0;
        for (int c = 6; c <= 7; c++) begin
            @(negedge clk); #1;
            check($sformatf("c%0d_busy", c), {31'b0, busy}, 32'd0);
            check($sformatf("c%0d_rv", c), {31'b0, redirect_valid}, 32'd0);
        end
        check("red_hold", redirect_pc, exp_red);
        check("stat_mem", mstatus, exp_stat);
        check("scratch_kept", mscratch, 32'h0000_00FF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rv", {31'b0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Passthrough in IDLE
        @(negedge clk);
        pipe_csr_addr = 12'h340; pipe_csr_wdata = 32'hF0; pipe_csr_we = 2'b10;
        #1;
        check("pt_we", {30'b0, csr_we}, 32'd2);
        check("pt_addr", {20'b0, csr_addr}, 32'h340);
        check("pt_wdata", csr_wdata, 32'hF0);
        check("pt_stall", {31'b0, pipe_csr_stall}, 32'd0);
        check("pt_rdata0", pipe_csr_rdata, 32'h0F);
        @(negedge clk);
        pipe_csr_we = 2'b00;
        #1;
        check("pt_rdata1", pipe_csr_rdata, 32'hFF);

        // Exception, vectored mtvec but synchronous cause -> base
        pipe_write(12'h305, 32'h8000_0101);
        pipe_write(12'h300, 32'h0000_0008);
        run_trap(32'h100, 32'h2, 32'hDEAD, 1'b0, 32'h100, 32'h1880, 32'h8000_0100);
        check("t2_epc", mepc, 32'h100);
        check("t2_cause", mcause, 32'h2);
        check("t2_tval", mtval, 32'hDEAD);

        // Vectored interrupt; misaligned pc gets its low bits cleared
        run_trap(32'h206, 32'h8000_0007, 32'h0, 1'b0, 32'h204, 32'h1800, 32'h8000_011C);

        // MRET
        pipe_write(12'h300, 32'h1880);
        pipe_write(12'h341, 32'h104);
        @(negedge clk);
        mret_req = 1'b1;
        #1;
        check("m0_stall", {31'b0, pipe_csr_stall}, 32'd1);
        check("m0_we", {30'b0, csr_we}, 32'd0);
        @(negedge clk);
        mret_req = 1'b0;
        #1;
        check("m1_addr", {20'b0, csr_addr}, 32'h300);
        check("m1_we", {30'b0, csr_we}, 32'd1);
        check("m1_wdata", csr_wdata, 32'h1888);
        check("m1_busy", {31'b0, busy}, 32'd1);
        @(negedge clk); #1;
        check("m2_we", {30'b0, csr_we}, 32'd0);
        check("m2_addr", {20'b0, csr_addr}, 32'd0);
        check("m2_rv", {31'b0, redirect_valid}, 32'd0);
        check("m2_busy", {31'b0, busy}, 32'd1);
        @(negedge clk); #1;
        check("m3_rv", {31'b0, redirect_valid}, 32'd1);
        check("m3_rpc", redirect_pc, 32'h104);
        check("m3_we", {30'b0, csr_we}, 32'd0);
        @(negedge clk); #1;
        check("m4_busy", {31'b0, busy}, 32'd0);
        check("m4_rv", {31'b0, redirect_valid}, 32'd0);
        check("m_stat", mstatus, 32'h1888);

        // Simultaneous trap & mret, plus mret during busy: trap only
        run_trap(32'h300, 32'h3, 32'h7, 1'b1, 32'h300, 32'h1880, 32'h8000_0100);

        // Reset while in T_TVAL
        @(negedge clk);
        trap_req = 1'b1; trap_pc = 32'h200; trap_cause = 32'h5; trap_tval = 32'hBEEF;
        @(negedge clk);
        trap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("r_we_in_rst", {30'b0, csr_we}, 32'd0);
        check("r_rv_in_rst", {31'b0, redirect_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("r_busy", {31'b0, busy}, 32'd0);
        check("r_we", {30'b0, csr_we}, 32'd0);
        check("r_rpc", redirect_pc, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check("r_no_rv", {31'b0, redirect_valid}, 32'd0);
        end
        check("r_epc", mepc, 32'h200);
        check("r_cause", mcause, 32'h5);
        check("r_tval", mtval, 32'h7);
        check("r_stat", mstatus, 32'h1880);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
